// File: rtl/pad_report_encoder.sv
// Game-pad report encoder: turns single button presses into coordinate/opcode
// reports, sent either as a 2*CW-bit serial frame or as a parallel valid/ready word.
module pad_report_encoder #(
    parameter int unsigned CW     = 4,
    parameter int unsigned X_INIT = 10,
    parameter int unsigned Y_INIT = 8,
    parameter int unsigned WRAP   = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic            L,
    input  logic            R,
    input  logic            U,
    input  logic            D,
    input  logic            A,
    input  logic            B,
    input  logic            X,
    input  logic            Y,
    input  logic            par_ready,
    output logic            ser_coord,
    output logic            ser_op,
    output logic            ser_frame,
    output logic [2*CW-1:0] par_coord,
    output logic [3:0]      par_op,
    output logic            par_valid,
    output logic            busy
);

    localparam int unsigned NBITS = 2 * CW;
    localparam int unsigned CNT_W = $clog2(NBITS);
    localparam logic [CW-1:0]    CMAX     = '1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_SEND_S = 2'd2,
        S_SEND_P = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        prev_q, prev_d;
    logic [7:0]        ev_q, ev_d;
    logic              mode_q, mode_d;
    logic [CW-1:0]     x_q, x_d;
    logic [CW-1:0]     y_q, y_d;
    logic [3:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ser_coord_q, ser_coord_d;
    logic              ser_op_q, ser_op_d;
    logic              ser_frame_q, ser_frame_d;
    logic [NBITS-1:0]  par_coord_q, par_coord_d;
    logic [3:0]        par_op_q, par_op_d;
    logic              par_valid_q, par_valid_d;
    logic              busy_q, busy_d;

    logic [7:0]        btn;
    logic [7:0]        btn_rise;
    logic              single_rise;
    logic [NBITS-1:0]  coord_sh;
    logic [NBITS-1:0]  op_sh;

    // Increment with saturation or wrap at the top of the range
    function automatic logic [CW-1:0] coord_up(input logic [CW-1:0] v);
        if (v == CMAX) begin
            return (WRAP != 0) ? '0 : CMAX;
        end
        return v + CW'(1);
    endfunction

    // Decrement with saturation or wrap at zero
    function automatic logic [CW-1:0] coord_dn(input logic [CW-1:0] v);
        if (v == '0) begin
            return (WRAP != 0) ? CMAX : '0;
        end
        return v - CW'(1);
    endfunction

    assign btn         = {L, R, U, D, A, B, X, Y};
    assign btn_rise    = btn & ~prev_q;
    assign single_rise = (btn_rise != '0) && ((btn_rise & (btn_rise - 8'd1)) == '0);
    assign coord_sh    = {x_q, y_q} << cnt_q;
    assign op_sh       = (NBITS'(op_q) << (NBITS - 4)) << cnt_q;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        prev_d      = btn;
        ev_d        = ev_q;
        mode_d      = mode_q;
        x_d         = x_q;
        y_d         = y_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        ser_coord_d = 1'b0;
        ser_op_d    = 1'b0;
        ser_frame_d = 1'b0;
        par_coord_d = par_coord_q;
        par_op_d    = par_op_q;
        par_valid_d = par_valid_q;

        case (state_q)
            S_IDLE: begin
                if (single_rise) begin
                    ev_d    = btn_rise;
                    mode_d  = mode;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                op_d = 4'b0000;
                if (ev_q[7]) x_d = coord_dn(x_q);
                if (ev_q[6]) x_d = coord_up(x_q);
                if (ev_q[5]) y_d = coord_up(y_q);
                if (ev_q[4]) y_d = coord_dn(y_q);
                if (ev_q[3]) op_d = 4'b1001;
                if (ev_q[2]) op_d = 4'b1011;
                if (ev_q[1]) op_d = 4'b1101;
                if (ev_q[0]) op_d = 4'b1111;
                cnt_d   = '0;
                state_d = mode_q ? S_SEND_S : S_SEND_P;
            end
            S_SEND_S: begin
                ser_frame_d = 1'b1;
                ser_coord_d = coord_sh[NBITS-1];
                ser_op_d    = op_sh[NBITS-1];
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND_P: begin
                par_coord_d = {x_q, y_q};
                par_op_d    = op_q;
                if (par_valid_q && par_ready) begin
                    par_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    par_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            ev_q        <= '0;
            mode_q      <= 1'b0;
            x_q         <= CW'(X_INIT);
            y_q         <= CW'(Y_INIT);
            op_q        <= '0;
            cnt_q       <= '0;
            ser_coord_q <= 1'b0;
            ser_op_q    <= 1'b0;
            ser_frame_q <= 1'b0;
            par_coord_q <= {CW'(X_INIT), CW'(Y_INIT)};
            par_op_q    <= '0;
            par_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            ev_q        <= ev_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            ser_coord_q <= ser_coord_d;
            ser_op_q    <= ser_op_d;
            ser_frame_q <= ser_frame_d;
            par_coord_q <= par_coord_d;
            par_op_q    <= par_op_d;
            par_valid_q <= par_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign ser_coord = ser_coord_q;
    assign ser_op    = ser_op_q;
    assign ser_frame = ser_frame_q;
    assign par_coord = par_coord_q;
    assign par_op    = par_op_q;
    assign par_valid = par_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pad_report_encoder.sv
// Scoreboard bench: one saturating and one wrapping encoder share stimulus;
// a transaction-level model predicts reports, a monitor checks them.
module tb_pad_report_encoder;

    localparam int unsigned CW   = 4;
    localparam int unsigned NB   = 2 * CW;
    localparam int          XI   = 10;
    localparam int          YI   = 8;
    localparam int          CMAX = 15;

    localparam logic [7:0] B_L = 8'h80, B_R = 8'h40, B_U = 8'h20, B_D = 8'h10;
    localparam logic [7:0] B_A = 8'h08, B_B = 8'h04;

    typedef struct packed {
        logic       ser;
        logic [7:0] coord;
        logic [3:0] op;
    } rep_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       par_ready;
    logic [7:0] btn;

    logic       ser_coord_w [2];
    logic       ser_op_w    [2];
    logic       ser_frame_w [2];
    logic [7:0] par_coord_w [2];
    logic [3:0] par_op_w    [2];
    logic       par_valid_w [2];
    logic       busy_w      [2];

    rep_t exp_q [2][$];

    int   nerr = 0;
    int   nchk = 0;
    bit   started = 1'b0;

    // transaction-level model state
    int         ecnt = 0;
    int         avail = 0;
    int         vfrom = 0;
    bit         pp = 1'b0;
    bit         exp_busy = 1'b0;
    logic [7:0] mprev = '0;
    int         mx [2];
    int         my [2];

    always #5 clk = ~clk;

    pad_report_encoder #(.CW(CW), .X_INIT(XI), .Y_INIT(YI), .WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .mode(mode),
        .L(btn[7]), .R(btn[6]), .U(btn[5]), .D(btn[4]),
        .A(btn[3]), .B(btn[2]), .X(btn[1]), .Y(btn[0]),
        .par_ready(par_ready),
        .ser_coord(ser_coord_w[0]), .ser_op(ser_op_w[0]), .ser_frame(ser_frame_w[0]),
        .par_coord(par_coord_w[0]), .par_op(par_op_w[0]), .par_valid(par_valid_w[0]),
        .busy(busy_w[0])
    );

    pad_report_encoder #(.CW(CW), .X_INIT(XI), .Y_INIT(YI), .WRAP(1)) u_wrap (
        .clk(clk), .reset(reset), .mode(mode),
        .L(btn[7]), .R(btn[6]), .U(btn[5]), .D(btn[4]),
        .A(btn[3]), .B(btn[2]), .X(btn[1]), .Y(btn[0]),
        .par_ready(par_ready),
        .ser_coord(ser_coord_w[1]), .ser_op(ser_op_w[1]), .ser_frame(ser_frame_w[1]),
        .par_coord(par_coord_w[1]), .par_op(par_op_w[1]), .par_valid(par_valid_w[1]),
        .busy(busy_w[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, got, want);
        end
    endtask

    function automatic int bump(input int v, input int delta, input bit wrap);
        int nv;
        nv = v + delta;
        if (nv < 0 || nv > CMAX) return wrap ? (nv + CMAX + 1) % (CMAX + 1) : v;
        return nv;
    endfunction

    // Predict the effect of the upcoming clock edge given the inputs just driven
    task automatic model_edge(input logic [7:0] b, input logic m, input logic rdy, input logic rs);
        int         n;
        int         k;
        logic [7:0] ev;
        bit         idle;
        rep_t       e;
        n = ecnt;
        k = 0;
        if (rs) begin
            mprev = '0;
            for (int d = 0; d < 2; d++) begin
                mx[d] = XI;
                my[d] = YI;
            end
            avail    = n + 1;
            pp       = 1'b0;
            exp_busy = 1'b0;
            return;
        end
        ev    = b & ~mprev;
        mprev = b;
        idle  = (n >= avail) && !pp;
        if (idle && $countones(ev) == 1) begin
            for (int i = 0; i < 8; i++) if (ev[i]) k = i;
            for (int d = 0; d < 2; d++) begin
                e.op = 4'd0;
                case (k)
                    7: mx[d] = bump(mx[d], -1, d == 1);
                    6: mx[d] = bump(mx[d], 1, d == 1);
                    5: my[d] = bump(my[d], 1, d == 1);
                    4: my[d] = bump(my[d], -1, d == 1);
                    3: e.op = 4'd9;
                    2: e.op = 4'd11;
                    1: e.op = 4'd13;
                    default: e.op = 4'd15;
                endcase
                e.ser   = m;
                e.coord = 8'((mx[d] << 4) + my[d]);
                exp_q[d].push_back(e);
            end
            if (m) begin
                avail = n + 2 + NB;
            end else begin
                pp    = 1'b1;
                vfrom = n + 3;
            end
        end else if (pp && n >= vfrom && rdy) begin
            pp    = 1'b0;
            avail = n + 1;
        end
        exp_busy = (n + 1 < avail) || pp;
    endtask

    // One cycle: check busy from the last edge, then drive inputs for the next edge
    task automatic step(input logic [7:0] b, input logic m, input logic rdy, input logic rs);
        @(negedge clk);
        if (started) begin
            for (int d = 0; d < 2; d++) chk("busy", d, 32'(busy_w[d]), 32'(exp_busy));
        end
        btn       = b;
        mode      = m;
        par_ready = rdy;
        reset     = rs;
        model_edge(b, m, rdy, rs);
        ecnt++;
    endtask

    task automatic idle(input int n, input logic m);
        for (int i = 0; i < n; i++) step(8'h00, m, 1'b1, 1'b0);
    endtask

    // Monitor: rebuild serial frames and parallel handshakes, compare with scoreboard
    initial begin
        int         bcnt   [2];
        logic [7:0] sc     [2];
        logic [7:0] so     [2];
        bit         pv_prev[2];
        bit         hs_prev[2];
        logic [7:0] pc_prev[2];
        logic [3:0] po_prev[2];
        logic [7:0] exp_pc [2];
        rep_t       e;
        for (int d = 0; d < 2; d++) begin
            bcnt[d] = 0; sc[d] = '0; so[d] = '0;
            pv_prev[d] = 1'b0; hs_prev[d] = 1'b0;
            pc_prev[d] = '0; po_prev[d] = '0;
            exp_pc[d] = 8'((XI << 4) + YI);
        end
        forever begin
            @(negedge clk);
            #1;
            if (!started) continue;
            for (int d = 0; d < 2; d++) begin
                if (ser_frame_w[d] === 1'b1) begin
                    sc[d] = {sc[d][6:0], ser_coord_w[d]};
                    so[d] = {so[d][6:0], ser_op_w[d]};
                    bcnt[d]++;
                    if (bcnt[d] == NB) begin
                        bcnt[d] = 0;
                        nchk++;
                        if (exp_q[d].size() == 0) begin
                            nerr++;
                            $display("FAIL unexpected_frame dut%0d: got coord %0h op %0h, no report expected", d, sc[d], so[d]);
                        end else begin
                            e = exp_q[d].pop_front();
                            chk("frame_kind", d, 32'(1), 32'(e.ser));
                            chk("ser_coord", d, 32'(sc[d]), 32'(e.coord));
                            chk("ser_op", d, 32'(so[d]), 32'({e.op, 4'b0000}));
                        end
                    end
                end else begin
                    chk("ser_idle_lines", d, 32'({ser_coord_w[d], ser_op_w[d]}), 32'(0));
                    if (bcnt[d] != 0 && !reset) begin
                        nchk++; nerr++;
                        $display("FAIL short_frame dut%0d: got %0d bits expected %0d", d, bcnt[d], NB);
                    end
                    bcnt[d] = 0;
                end

                if (hs_prev[d]) chk("valid_after_hs", d, 32'(par_valid_w[d]), 32'(0));
                if (par_valid_w[d] === 1'b1) begin
                    if (pv_prev[d] && !hs_prev[d]) begin
                        chk("par_coord_stable", d, 32'(par_coord_w[d]), 32'(pc_prev[d]));
                        chk("par_op_stable", d, 32'(par_op_w[d]), 32'(po_prev[d]));
                    end
                    if (par_ready) begin
                        nchk++;
                        if (exp_q[d].size() == 0) begin
                            nerr++;
                            $display("FAIL unexpected_par dut%0d: got coord %0h op %0h, no report expected", d, par_coord_w[d], par_op_w[d]);
                        end else begin
                            e = exp_q[d].pop_front();
                            chk("par_kind", d, 32'(0), 32'(e.ser));
                            chk("par_coord", d, 32'(par_coord_w[d]), 32'(e.coord));
                            chk("par_op", d, 32'(par_op_w[d]), 32'(e.op));
                            exp_pc[d] = e.coord;
                        end
                    end
                end else begin
                    chk("par_coord_hold", d, 32'(par_coord_w[d]), 32'(exp_pc[d]));
                end
                pv_prev[d] = (par_valid_w[d] === 1'b1);
                hs_prev[d] = (par_valid_w[d] === 1'b1) && par_ready;
                pc_prev[d] = par_coord_w[d];
                po_prev[d] = par_op_w[d];

                if (reset) begin
                    exp_q[d].delete();
                    bcnt[d]    = 0;
                    pv_prev[d] = 1'b0;
                    hs_prev[d] = 1'b0;
                    exp_pc[d]  = 8'((XI << 4) + YI);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by random traffic
    initial begin
        logic [7:0] lastb;
        logic [7:0] b;
        reset = 1'b1; btn = '0; mode = 1'b0; par_ready = 1'b0;
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        started = 1'b1;
        idle(3, 1'b0);

        // parallel R press with a stalled sink
        step(B_R, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);

        // serial A press
        step(B_A, 1'b1, 1'b1, 1'b0);
        idle(12, 1'b1);

        // drive X past the top, Y past zero
        for (int i = 0; i < 6; i++) begin
            step(B_R, 1'(i % 2), 1'b1, 1'b0);
            idle(12, 1'(i % 2));
        end
        for (int i = 0; i < 10; i++) begin
            step(B_D, 1'(i % 2), 1'b1, 1'b0);
            idle(12, 1'(i % 2));
        end

        // multi-bit presses are ignored
        step(B_L | B_R, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
        step(B_U | B_B, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b0);

        // held button, then a press during a serial frame
        for (int i = 0; i < 20; i++) step(B_R, 1'b1, 1'b1, 1'b0);
        idle(12, 1'b1);
        step(B_A, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(B_U, 1'b0, 1'b1, 1'b0);
        idle(12, 1'b0);

        // reset during the 4th serial bit
        step(B_B, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);
        step(8'h00, 1'b1, 1'b1, 1'b1);
        idle(5, 1'b0);
        step(B_U, 1'b0, 1'b1, 1'b0);
        idle(6, 1'b0);

        // random traffic
        lastb = '0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8)       b = 8'(1 << $urandom_range(0, 7));
            else if (r < 10) b = 8'((1 << $urandom_range(0, 7)) | (1 << $urandom_range(0, 7)));
            else if (r < 25) b = lastb;
            else             b = '0;
            lastb = b;
            step(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 599) == 0));
        end

        idle(40, 1'b0);
        for (int d = 0; d < 2; d++) chk("reports_left", d, 32'(exp_q[d].size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
